// File: rtl/csa_operand_feeder.sv
// csa_operand_feeder
//
// Upstream stage for a 3-operand 4-bit carry-save adder. Collects 4-bit
// operands from a valid/ready stream into triples, drives them onto the
// adder inputs, captures the 6-bit adder result and presents it downstream
// over a second valid/ready handshake. Each captured result is also added
// into a running accumulator, which clears once the packet's last result
// is accepted.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_data/in_valid/in_last  operand stream in; in_last marks end of packet
//   in_ready                  operand can be accepted this cycle
//   csa_x/csa_y/csa_z         operand slots driven to the adder
//   csa_sum/csa_cout          adder result {cout, sum[4:0]}
//   res_data/res_last         captured group result and end-of-packet flag
//   res_valid/res_ready       result handshake
//   acc_data                  running packet sum, including current res_data
//   acc_valid                 res_valid & res_last
//   acc_ovf                   sticky: packet sum exceeded 2^ACC_W-1
//
// State    | meaning
// ---------+---------------------------------------------------------------
// COLLECT  | accepting operands into slots x, y, z (in_ready=1)
// CAPTURE  | slots stable, adder settles, result and accumulator registered
// OUTPUT   | result presented, held until res_ready

module csa_operand_feeder #(
  parameter int ACC_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [3:0]       csa_x,
  output logic [3:0]       csa_y,
  output logic [3:0]       csa_z,
  input  logic [4:0]       csa_sum,
  input  logic             csa_cout,
  output logic [5:0]       res_data,
  output logic             res_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] acc_data,
  output logic             acc_valid,
  output logic             acc_ovf
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CAPTURE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] cnt;
  logic       last_q;

  logic           accept;
  logic           closing;
  logic [5:0]     grp_res;
  logic [ACC_W:0] acc_sum;

  assign accept  = in_valid & in_ready;
  // A group closes on its third operand or on any operand flagged last.
  assign closing = accept & (in_last | (cnt == 2'd2));
  assign grp_res = {csa_cout, csa_sum};
  // One extra bit on top of the accumulator catches the wrap for acc_ovf.
  assign acc_sum = {1'b0, acc_data} + {{(ACC_W - 5){1'b0}}, grp_res};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      cnt       <= 2'd0;
      last_q    <= 1'b0;
      in_ready  <= 1'b0;
      csa_x     <= 4'd0;
      csa_y     <= 4'd0;
      csa_z     <= 4'd0;
      res_data  <= 6'd0;
      res_last  <= 1'b0;
      res_valid <= 1'b0;
      acc_data  <= '0;
      acc_valid <= 1'b0;
      acc_ovf   <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          // Also raises in_ready on the first cycle out of reset.
          in_ready <= ~closing;
          if (accept) begin
            case (cnt)
              2'd0:    csa_x <= in_data;
              2'd1:    csa_y <= in_data;
              default: csa_z <= in_data;
            endcase
            if (closing) begin
              last_q <= in_last;
              state  <= CAPTURE;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end

        CAPTURE: begin
          res_data  <= grp_res;
          res_last  <= last_q;
          res_valid <= 1'b1;
          acc_valid <= last_q;
          acc_data  <= acc_sum[ACC_W-1:0];
          if (acc_sum[ACC_W]) begin
            acc_ovf <= 1'b1;
          end
          state <= OUTPUT;
        end

        OUTPUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            acc_valid <= 1'b0;
            res_last  <= 1'b0;
            csa_x     <= 4'd0;
            csa_y     <= 4'd0;
            csa_z     <= 4'd0;
            cnt       <= 2'd0;
            last_q    <= 1'b0;
            in_ready  <= 1'b1;
            state     <= COLLECT;
            // The packet is complete once its last result is taken.
            if (res_last) begin
              acc_data <= '0;
              acc_ovf  <= 1'b0;
            end
          end
        end

        default: begin
          state    <= COLLECT;
          cnt      <= 2'd0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_operand_feeder.sv
module tb_csa_operand_feeder;

  localparam int ACC_W = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [3:0]       csa_x, csa_y, csa_z;
  logic [4:0]       csa_sum;
  logic             csa_cout;
  logic [5:0]       res_data;
  logic             res_last;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] acc_data;
  logic             acc_valid;
  logic             acc_ovf;

  always #5 clk = ~clk;

  // Adder stand-in: exact 3-operand sum, range 0..45.
  assign {csa_cout, csa_sum} = 6'(csa_x) + 6'(csa_y) + 6'(csa_z);

  csa_operand_feeder #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .csa_x     (csa_x),
    .csa_y     (csa_y),
    .csa_z     (csa_z),
    .csa_sum   (csa_sum),
    .csa_cout  (csa_cout),
    .res_data  (res_data),
    .res_last  (res_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .acc_data  (acc_data),
    .acc_valid (acc_valid),
    .acc_ovf   (acc_ovf)
  );

  // Reference model: the current group as a list of operands, whether it is
  // complete, whether its result has been captured, and the true packet sum.
  int grp[$];
  bit grp_done;
  bit captured;
  bit grp_last;
  int acc_true;
  bit rst_just;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int grp_sum();
    int s = 0;
    foreach (grp[i]) s += grp[i];
    return s;
  endfunction

  function automatic int slot(input int i);
    return (i < grp.size()) ? grp[i] : 0;
  endfunction

  // One clock cycle: check outputs against the model, drive inputs,
  // advance the model across the rising edge, then settle at the falling edge.
  task automatic cyc(input bit v, input logic [3:0] d, input bit l, input bit rr, input bit r);
    int lim = 1 << ACC_W;
    bit acc_hs;
    bit out_hs;
    bit showing;
    showing = grp_done && captured;

    chk("in_ready",  in_ready,  32'(!rst_just && !grp_done));
    chk("csa_x",     csa_x,     slot(0));
    chk("csa_y",     csa_y,     slot(1));
    chk("csa_z",     csa_z,     slot(2));
    chk("res_valid", res_valid, 32'(showing));
    chk("acc_valid", acc_valid, 32'(showing && grp_last));
    chk("acc_data",  acc_data,  acc_true % lim);
    chk("acc_ovf",   acc_ovf,   32'(acc_true >= lim));
    if (showing) begin
      chk("res_data", res_data, grp_sum());
      chk("res_last", res_last, 32'(grp_last));
    end
    if (rst_just) begin
      chk("rst_res_data", res_data, 0);
      chk("rst_res_last", res_last, 0);
    end

    rst       = r;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    res_ready = rr;
    acc_hs = v && !rst_just && !grp_done;
    out_hs = rr && showing;

    @(posedge clk);
    if (r) begin
      grp.delete();
      grp_done = 0;
      captured = 0;
      grp_last = 0;
      acc_true = 0;
    end else if (grp_done && !captured) begin
      acc_true += grp_sum();
      captured = 1;
    end else if (out_hs) begin
      if (grp_last) acc_true = 0;
      grp.delete();
      grp_done = 0;
      captured = 0;
      grp_last = 0;
    end else if (acc_hs) begin
      grp.push_back(int'(d));
      if (l || grp.size() == 3) begin
        grp_done = 1;
        grp_last = l;
      end
    end
    rst_just = r;
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    in_last   = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    grp.delete();
    grp_done = 0;
    captured = 0;
    grp_last = 0;
    acc_true = 0;
    rst_just = 1;

    // Reset state is checked by the first cycle; in_ready comes up after it.
    cyc(0, 4'd0, 0, 0, 0);

    // 1,2,3 with last; result visible two cycles after the third accept.
    cyc(1, 4'd1, 0, 1, 0);
    cyc(1, 4'd2, 0, 1, 0);
    cyc(1, 4'd3, 1, 1, 0);
    chk("t1_capture_valid", res_valid, 0);
    cyc(0, 4'd0, 0, 1, 0);
    chk("t1_res", res_data, 6);
    chk("t1_acc", acc_data, 6);
    chk("t1_accv", acc_valid, 1);
    cyc(0, 4'd0, 0, 1, 0);

    // 15,15,15 without last: carry-out reaches bit 5.
    repeat (3) cyc(1, 4'd15, 0, 1, 0);
    cyc(0, 4'd0, 0, 1, 0);
    chk("t2_res", res_data, 45);
    chk("t2_last", res_last, 0);
    chk("t2_acc", acc_data, 45);
    cyc(0, 4'd0, 0, 1, 0);

    // Short group 7,9 with last, then a single operand 4 with last.
    cyc(1, 4'd7, 0, 1, 0);
    cyc(1, 4'd9, 1, 1, 0);
    cyc(0, 4'd0, 0, 1, 0);
    chk("t3_z", csa_z, 0);
    chk("t3_res", res_data, 16);
    chk("t3_last", res_last, 1);
    cyc(0, 4'd0, 0, 1, 0);
    cyc(1, 4'd4, 1, 1, 0);
    cyc(0, 4'd0, 0, 1, 0);
    chk("t4_x", csa_x, 4);
    chk("t4_y", csa_y, 0);
    chk("t4_res", res_data, 4);
    chk("t4_acc", acc_data, 4);
    cyc(0, 4'd0, 0, 1, 0);

    // 23 groups of 45: 1035 wraps to 11 with overflow, then clears.
    for (int g = 0; g < 23; g++) begin
      for (int k = 0; k < 3; k++) cyc(1, 4'd15, (g == 22) && (k == 2), 1, 0);
      cyc(0, 4'd0, 0, 1, 0);
      if (g == 22) begin
        chk("t5_acc", acc_data, 11);
        chk("t5_ovf", acc_ovf, 1);
      end
      cyc(0, 4'd0, 0, 1, 0);
    end
    chk("t5_acc_clr", acc_data, 0);
    chk("t5_ovf_clr", acc_ovf, 0);

    // Downstream stall for 10 cycles with an operand waiting.
    cyc(1, 4'd1, 0, 1, 0);
    cyc(1, 4'd2, 0, 1, 0);
    cyc(1, 4'd3, 0, 1, 0);
    cyc(1, 4'd5, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("stall_res", res_data, 6);
      chk("stall_ready", in_ready, 0);
      cyc(1, 4'd5, 0, 0, 0);
    end
    cyc(1, 4'd5, 0, 1, 0);
    cyc(1, 4'd5, 0, 0, 0);
    chk("stall_first_x", csa_x, 5);
    cyc(1, 4'd6, 0, 1, 0);
    cyc(1, 4'd7, 1, 1, 0);
    cyc(0, 4'd0, 0, 1, 0);
    cyc(0, 4'd0, 0, 1, 0);

    // Reset mid-group discards the partial slots.
    cyc(1, 4'd1, 0, 1, 0);
    cyc(1, 4'd2, 0, 1, 0);
    cyc(0, 4'd0, 0, 0, 1);
    chk("rst_x", csa_x, 0);
    chk("rst_y", csa_y, 0);
    cyc(0, 4'd0, 0, 0, 0);
    cyc(1, 4'd3, 0, 1, 0);
    cyc(1, 4'd4, 0, 1, 0);
    cyc(1, 4'd5, 0, 1, 0);
    cyc(0, 4'd0, 0, 1, 0);
    chk("rst_fresh_res", res_data, 12);
    cyc(0, 4'd0, 0, 1, 0);

    // Random traffic, backpressure and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
          $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 149) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
